ps2_host_tx: RTL and testbench
==============================

// Module: ps2_host_tx
// PURPOSE
//  Host-to-device PS/2 transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard
//  over the same open-drain clk/data pair the PS/2 key receiver listens on. Runs on clk_sys; the device
//  generates the bit clock. Pads are driven low via *_oe (pad = oe ? 0 : Z, pulled up).
//  tx_active gates the key receiver while a command is in flight.
// PARAMETERS
//  CLK_HZ         52000000  clk_sys frequency; all µs timings derive from it (cycles = CLK_HZ/1e6 * us)
//  INHIBIT_US     120       host holds ps2_clk low before request-to-send
//  START_TMO_US   15000     max wait from clk release to first device falling edge
//  XFER_TMO_US    2000      max time from first falling edge to ACK
//  FILTER_LEN     8         clk_sys cycles a synchronised input must be stable before it is accepted
// PORTS
//  clk_sys      in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  tx_data      in   8  command byte
//  tx_valid     in   1  request; byte accepted when tx_valid & tx_ready
//  tx_ready     out  1  high only in IDLE
//  tx_active    out  1  high from acceptance until done pulse (inclusive)
//  done         out  1  one-cycle pulse at end of every accepted transfer
//  ack_err      out  1  valid with done: device did not pull data low at ACK
//  tmo_err      out  1  valid with done: start or transfer timeout
//  ps2_clk_in   in   1  pad clock (async)
//  ps2_data_in  in   1  pad data (async)
//  ps2_clk_oe   out  1  1 = pull clock low
//  ps2_data_oe  out  1  1 = pull data low
// BEHAVIOUR
//  Reset (async): state IDLE, tx_ready=1, tx_active=0, done=0, ack_err=0, tmo_err=0,
//    ps2_clk_oe=0, ps2_data_oe=0, filters loaded with 1.
//  Reset mid-transfer releases both lines immediately; no done pulse.
//  Inputs: 2-FF sync, then FILTER_LEN stability filter; fall = filtered clk 1->0 (one-cycle strobe).
//  Accept: tx_valid & tx_ready latches tx_data, computes odd parity p = ~^tx_data, next cycle INHIBIT.
//  FSM:
//   IDLE     -> INHIBIT on accept.
//   INHIBIT  clk_oe=1 for INHIBIT_US; on expiry data_oe=1 (start bit), then REQ next cycle.
//   REQ      clk_oe=0, data_oe=1; first fall -> BITS (bit idx 0 driven), else START_TMO_US -> FAIL(tmo).
//   BITS     on each fall drive next bit: data_oe = ~bit; order D0..D7, parity, stop (data_oe=0);
//            10 falls total after release; data changes only in the cycle after fall.
//   ACK      on 11th fall sample filtered data: 0 = ok, 1 = ack_err; -> WAITIDLE.
//   WAITIDLE wait filtered clk=1 & data=1 -> DONE.
//   DONE     done=1 for one cycle with status, -> IDLE.
//   FAIL     release both lines, done=1, tmo_err=1, -> IDLE.
//  XFER_TMO_US counter starts at first fall, checked in BITS/ACK/WAITIDLE -> FAIL(tmo) when expired.
//  ack_err/tmo_err hold until next accept; never both set.
//  tx_valid while busy ignored (no back-pressure loss: source must wait for tx_ready).
//  Falls arriving in INHIBIT (device noise) ignored; extra falls after ACK ignored.
//  Counters sized $clog2 of max cycle count; no wrap within a transfer.
// TESTING (bench uses CLK_HZ=1000000 for speed; device model clocks at ~12.5 kHz)
//  1. Send 0xED: clk held low 120 cycles; data bits 1,0,1,1,0,1,1,1, parity 1, stop 1;
//     model ACKs -> done=1, ack_err=0, tmo_err=0.
//  2. Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0; model captures exact bytes.
//  3. Model never clocks -> at 15000 cycles after clk release done=1, tmo_err=1, both oe=0.
//  4. Model omits ACK (data high on 11th fall) -> done=1, ack_err=1.
//  5. Assert reset during bit 4 -> oe outputs 0 in same cycle, no done pulse, tx_ready=1.
//  6. 3-cycle glitch on ps2_clk_in during BITS -> ignored, bit sequence unchanged.

Source files
------------

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues request-to-send, and shifts one
// command byte out on device-generated clock falls, then samples the device ACK.
module ps2_host_tx #(
    parameter int unsigned CLK_HZ       = 52000000,
    parameter int unsigned INHIBIT_US   = 120,
    parameter int unsigned START_TMO_US = 15000,
    parameter int unsigned XFER_TMO_US  = 2000,
    parameter int unsigned FILTER_LEN   = 8
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_active,
    output logic       done,
    output logic       ack_err,
    output logic       tmo_err,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int unsigned CycPerUs = CLK_HZ / 1000000;
    localparam int unsigned InhCyc   = CycPerUs * INHIBIT_US;
    localparam int unsigned StartCyc = CycPerUs * START_TMO_US;
    localparam int unsigned XferCyc  = CycPerUs * XFER_TMO_US;
    localparam int unsigned MaxAB    = (InhCyc > StartCyc) ? InhCyc : StartCyc;
    localparam int unsigned MaxCyc   = (MaxAB > XferCyc) ? MaxAB : XferCyc;
    localparam int unsigned TmrW     = $clog2(MaxCyc + 1);
    localparam int unsigned FltW     = $clog2(FILTER_LEN + 1);

    localparam logic [TmrW-1:0] InhPre    = TmrW'(InhCyc - 2);
    localparam logic [TmrW-1:0] InhLast   = TmrW'(InhCyc - 1);
    localparam logic [TmrW-1:0] StartLast = TmrW'(StartCyc - 1);
    localparam logic [TmrW-1:0] XferLast  = TmrW'(XferCyc - 1);
    localparam logic [FltW-1:0] FltLast   = FltW'(FILTER_LEN - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInhibit,
        StReq,
        StBits,
        StAck,
        StWaitIdle,
        StDone,
        StFail
    } state_e;

    // Input conditioning: bit 0 = clock, bit 1 = data
    logic [1:0]           sync1_q, sync2_q, filt_q;
    logic [1:0][FltW-1:0] fcnt_q;
    logic                 clk_prev_q;
    logic                 fall;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sync1_q    <= 2'b11;
            sync2_q    <= 2'b11;
            filt_q     <= 2'b11;
            fcnt_q     <= '0;
            clk_prev_q <= 1'b1;
        end else begin
            sync1_q    <= {ps2_data_in, ps2_clk_in};
            sync2_q    <= sync1_q;
            clk_prev_q <= filt_q[0];
            for (int i = 0; i < 2; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    fcnt_q[i] <= '0;
                end else if (fcnt_q[i] == FltLast) begin
                    filt_q[i] <= sync2_q[i];
                    fcnt_q[i] <= '0;
                end else begin
                    fcnt_q[i] <= fcnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign fall = clk_prev_q & ~filt_q[0];

    state_e          state_q, state_d;
    logic [TmrW-1:0] tmr_q, tmr_d;
    logic [3:0]      idx_q, idx_d;
    logic [9:0]      frame_q, frame_d;
    logic            clk_oe_q, clk_oe_d;
    logic            data_oe_q, data_oe_d;
    logic            ack_err_q, ack_err_d;
    logic            tmo_err_q, tmo_err_d;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            tmr_q     <= '0;
            idx_q     <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ack_err_q <= 1'b0;
            tmo_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmr_q     <= tmr_d;
            idx_q     <= idx_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            ack_err_q <= ack_err_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q;
        idx_d     = idx_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        ack_err_d = ack_err_q;
        tmo_err_d = tmo_err_q;

        case (state_q)
            StIdle: begin
                if (tx_valid) begin
                    // frame = {stop, odd parity, D7..D0}
                    frame_d   = {1'b1, ~^tx_data, tx_data};
                    ack_err_d = 1'b0;
                    tmo_err_d = 1'b0;
                    tmr_d     = '0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = StInhibit;
                end
            end
            StInhibit: begin
                tmr_d = tmr_q + 1'b1;
                // start bit overlaps the last inhibit cycle so data is low before clk releases
                if (tmr_q == InhPre) begin
                    data_oe_d = 1'b1;
                end
                if (tmr_q == InhLast) begin
                    clk_oe_d = 1'b0;
                    tmr_d    = '0;
                    state_d  = StReq;
                end
            end
            StReq: begin
                tmr_d = tmr_q + 1'b1;
                if (fall) begin
                    tmr_d     = '0;
                    idx_d     = '0;
                    data_oe_d = ~frame_q[0];
                    state_d   = StBits;
                end else if (tmr_q == StartLast) begin
                    state_d = StFail;
                end
            end
            StBits: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == XferLast) begin
                    state_d = StFail;
                end else if (fall) begin
                    idx_d     = idx_q + 4'd1;
                    data_oe_d = ~frame_q[idx_q + 4'd1];
                    if (idx_q == 4'd8) begin
                        state_d = StAck;
                    end
                end
            end
            StAck: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == XferLast) begin
                    state_d = StFail;
                end else if (fall) begin
                    ack_err_d = filt_q[1];
                    state_d   = StWaitIdle;
                end
            end
            StWaitIdle: begin
                tmr_d = tmr_q + 1'b1;
                if (tmr_q == XferLast) begin
                    state_d = StFail;
                end else if (filt_q == 2'b11) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                data_oe_d = 1'b0;
                state_d   = StIdle;
            end
            StFail: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Timeout entry releases the bus and reports only the timeout
        if (state_d == StFail && state_q != StFail) begin
            clk_oe_d  = 1'b0;
            data_oe_d = 1'b0;
            tmo_err_d = 1'b1;
            ack_err_d = 1'b0;
        end
    end

    assign tx_ready    = (state_q == StIdle);
    assign tx_active   = (state_q != StIdle);
    assign done        = (state_q == StDone) || (state_q == StFail);
    assign ack_err     = ack_err_q;
    assign tmo_err     = tmo_err_q;
    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain bus model and a simple PS/2 device model.
module tb_ps2_host_tx;

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready, tx_active, done, ack_err, tmo_err;
    logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
    logic       dev_clk  = 1'b1;
    logic       dev_data = 1'b1;

    int n_run  = 0;
    int n_fail = 0;

    // Wired-AND pads with pull-ups
    assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
    assign ps2_data_in = dev_data & ~ps2_data_oe;

    ps2_host_tx #(
        .CLK_HZ      (1000000),
        .INHIBIT_US  (120),
        .START_TMO_US(15000),
        .XFER_TMO_US (2000),
        .FILTER_LEN  (8)
    ) dut (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_active  (tx_active),
        .done       (done),
        .ack_err    (ack_err),
        .tmo_err    (tmo_err),
        .ps2_clk_in (ps2_clk_in),
        .ps2_data_in(ps2_data_in),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk_sys = ~clk_sys;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    // Hand a byte to the DUT and measure how long the clock is held low
    task automatic start_xfer(input logic [7:0] b, input bit poke, output int inh);
        int w;
        w = 0;
        while (!tx_ready && w < 100) begin
            cyc(1);
            w++;
        end
        check_eq("ready_before_send", tx_ready, 1);
        tx_data  = b;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        inh = 0;
        while (ps2_clk_oe && inh < 1000) begin
            if (poke && inh == 50) begin
                tx_data  = 8'hFF;
                tx_valid = 1'b1;
            end else begin
                tx_valid = 1'b0;
            end
            inh++;
            cyc(1);
        end
        tx_valid = 1'b0;
    endtask

    // Device: 11 clock periods of 80 cycles, data sampled just before each rise
    task automatic dev_clock(input int npulse, input bit do_ack, input int glitch_at,
                             output logic [9:0] cap);
        cap = '0;
        if (npulse > 0) cyc(50);
        for (int i = 0; i < npulse; i++) begin
            if (i == 10 && do_ack) begin
                dev_data = 1'b0;
                cyc(20);
            end
            dev_clk = 1'b0;
            cyc(40);
            if (i < 10) cap[i] = ps2_data_in;
            dev_clk = 1'b1;
            if (i == 10) begin
                dev_data = 1'b1;
            end else if (i == glitch_at) begin
                cyc(15);
                dev_clk = 1'b0;
                cyc(3);
                dev_clk = 1'b1;
                cyc(22);
            end else begin
                cyc(40);
            end
        end
    endtask

    task automatic wait_done(input string tag, input bit exp_ack_err);
        int w;
        w = 0;
        while (!done && w < 3000) begin
            cyc(1);
            w++;
        end
        check_eq({tag, "_done"}, done, 1);
        check_eq({tag, "_active_at_done"}, tx_active, 1);
        check_eq({tag, "_ack_err"}, ack_err, exp_ack_err);
        check_eq({tag, "_tmo_err"}, tmo_err, 0);
        check_eq({tag, "_oe_released"}, {ps2_clk_oe, ps2_data_oe}, 2'b00);
        cyc(1);
        check_eq({tag, "_done_one_cycle"}, done, 0);
    endtask

    typedef struct {
        logic [7:0] b;
        logic       p;
        bit         ack;
        int         glitch;
        bit         poke;
        string      tag;
    } vec_t;

    vec_t       vecs[6];
    int         inh;
    int         n;
    bit         seen;
    logic [9:0] cap;

    initial begin
        vecs[0] = '{8'hED, 1'b1, 1'b1, -1, 1'b0, "x_ed"};
        vecs[1] = '{8'h00, 1'b1, 1'b1, -1, 1'b0, "x_00"};
        vecs[2] = '{8'h01, 1'b0, 1'b1, -1, 1'b1, "x_01"};
        vecs[3] = '{8'h3C, 1'b1, 1'b0, -1, 1'b0, "x_3c_noack"};
        vecs[4] = '{8'h80, 1'b0, 1'b1, 3, 1'b0, "x_80_glitch"};
        vecs[5] = '{8'hFF, 1'b1, 1'b1, -1, 1'b0, "x_ff"};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        cyc(3);
        check_eq("rst_ready", tx_ready, 1);
        check_eq("rst_active", tx_active, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_errs", {ack_err, tmo_err}, 2'b00);
        check_eq("rst_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        reset = 1'b0;
        cyc(20);

        for (int v = 0; v < 5; v++) begin
            start_xfer(vecs[v].b, vecs[v].poke, inh);
            check_eq({vecs[v].tag, "_inhibit_len"}, inh, 120);
            check_eq({vecs[v].tag, "_start_bit"}, ps2_data_oe, 1);
            check_eq({vecs[v].tag, "_active"}, tx_active, 1);
            dev_clock(11, vecs[v].ack, vecs[v].glitch, cap);
            check_eq({vecs[v].tag, "_frame"}, cap, {1'b1, vecs[v].p, vecs[v].b});
            wait_done(vecs[v].tag, !vecs[v].ack);
            cyc(10);
        end

        // Device never clocks: start timeout
        start_xfer(8'h55, 1'b0, inh);
        check_eq("tmo_inhibit_len", inh, 120);
        n = 0;
        while (!done && n < 20000) begin
            cyc(1);
            n++;
        end
        check_eq("tmo_cycles", n, 15000);
        check_eq("tmo_tmo_err", tmo_err, 1);
        check_eq("tmo_ack_err", ack_err, 0);
        check_eq("tmo_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        cyc(10);

        // Reset while bit 4 of 0xA5 (a zero) is on the bus
        start_xfer(8'hA5, 1'b0, inh);
        dev_clock(5, 1'b1, -1, cap);
        check_eq("rstmid_bit4_driven", ps2_data_oe, 1);
        check_eq("rstmid_bits_0_3", cap[3:0], 4'h5);
        #2;
        reset = 1'b1;
        #1;
        check_eq("rstmid_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
        check_eq("rstmid_ready", tx_ready, 1);
        cyc(2);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (done) seen = 1'b1;
        end
        check_eq("rstmid_no_done", seen, 0);
        check_eq("rstmid_ready_after", tx_ready, 1);

        // Clean transfer after the mid-transfer reset
        start_xfer(vecs[5].b, vecs[5].poke, inh);
        check_eq("x_ff_inhibit_len", inh, 120);
        dev_clock(11, vecs[5].ack, vecs[5].glitch, cap);
        check_eq("x_ff_frame", cap, {1'b1, vecs[5].p, vecs[5].b});
        wait_done(vecs[5].tag, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
